// File: rtl/aes128_package.sv
// rtl/aes128_package.sv - shared types and helpers for the masked datapath blocks
package aes128_package;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRESH = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_DONE    = 2'd3
    } unmask_state_t;

    localparam int MIN_SHARES = 2;
    localparam int MAX_SHARES = 5;

    // Fresh random words needed to build an n-share sharing of zero.
    function automatic int num_share_0(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/register.sv
// rtl/register.sv - plain D register with asynchronous active-high clear
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/share_zero.sv
// rtl/share_zero.sv - registered Boolean sharing of zero built from fresh randomness
module share_zero
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [num_share_0(NUM_SHARES)-1:0][BIT_WIDTH-1:0]     random,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                  zero_q
);

    localparam int NUM_RAND = num_share_0(NUM_SHARES);

    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] zero_d;

    // Each random word appears twice (its own slot and the last slot), so the total XOR is zero.
    always_comb begin
        zero_d = '0;
        for (int i = 0; i < NUM_RAND; i++) begin
            zero_d[i]            = random[i];
            zero_d[NUM_SHARES-1] = zero_d[NUM_SHARES-1] ^ random[i];
        end
    end

    register #(.WIDTH(NUM_SHARES * BIT_WIDTH)) u_zero_reg (
        .clk (clk),
        .rst (rst),
        .d   (zero_d),
        .q   (zero_q)
    );

endmodule

// File: rtl/share_unmask.sv
// rtl/share_unmask.sv - recombines Boolean shares one per cycle; SHARE_UNMASK_REFRESH_EN adds a share refresh step
module share_unmask
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2
) (
    input  logic                                       in_clock,
    input  logic                                       in_reset,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]       in_shares,
    input  logic                                       in_valid,
    output logic                                       out_ready,
    output logic [BIT_WIDTH-1:0]                       out_value,
    output logic                                       out_valid,
    input  logic                                       in_ready
`ifdef SHARE_UNMASK_REFRESH_EN
    ,
    input  logic [num_share_0(NUM_SHARES)-1:0][BIT_WIDTH-1:0] in_random
`endif
);

    localparam int IDX_W = $clog2(NUM_SHARES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SHARES - 1);

    generate
        if (NUM_SHARES < MIN_SHARES || NUM_SHARES > MAX_SHARES) begin : g_bad_shares
            $error("share_unmask: NUM_SHARES=%0d outside supported range 2..5", NUM_SHARES);
        end
    endgenerate

    logic [1:0]                           state_raw_q;
    unmask_state_t                        state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [BIT_WIDTH-1:0]                 acc_q, acc_d;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] share_q, share_d;
    logic                                 out_valid_q, out_valid_d;
    logic [BIT_WIDTH-1:0]                 out_value_q, out_value_d;

    assign state_q = unmask_state_t'(state_raw_q);

`ifdef SHARE_UNMASK_REFRESH_EN
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] zero_q;

    // Randomness is latched on the capture edge, so zero_q is ready in the REFRESH cycle.
    share_zero #(
        .NUM_SHARES (NUM_SHARES),
        .BIT_WIDTH  (BIT_WIDTH)
    ) u_share_zero (
        .clk    (in_clock),
        .rst    (in_reset),
        .random (in_random),
        .zero_q (zero_q)
    );
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        share_d     = share_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    share_d = in_shares;
                    acc_d   = '0;
                    idx_d   = '0;
`ifdef SHARE_UNMASK_REFRESH_EN
                    state_d = ST_REFRESH;
`else
                    state_d = ST_ACCUM;
`endif
                end
            end
`ifdef SHARE_UNMASK_REFRESH_EN
            ST_REFRESH: begin
                for (int i = 0; i < NUM_SHARES; i++) begin
                    share_d[i] = share_q[i] ^ zero_q[i];
                end
                state_d = ST_ACCUM;
            end
`endif
            ST_ACCUM: begin
                acc_d = acc_q ^ share_q[idx_q];
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_value_d = acc_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (in_ready) begin
                    state_d     = ST_IDLE;
                    share_d     = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                    out_value_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    register #(.WIDTH(2)) u_state_reg (
        .clk (in_clock), .rst (in_reset), .d (state_d), .q (state_raw_q)
    );
    register #(.WIDTH(IDX_W)) u_idx_reg (
        .clk (in_clock), .rst (in_reset), .d (idx_d), .q (idx_q)
    );
    register #(.WIDTH(BIT_WIDTH)) u_acc_reg (
        .clk (in_clock), .rst (in_reset), .d (acc_d), .q (acc_q)
    );
    register #(.WIDTH(NUM_SHARES * BIT_WIDTH)) u_share_reg (
        .clk (in_clock), .rst (in_reset), .d (share_d), .q (share_q)
    );
    register #(.WIDTH(1)) u_out_valid_reg (
        .clk (in_clock), .rst (in_reset), .d (out_valid_d), .q (out_valid_q)
    );
    register #(.WIDTH(BIT_WIDTH)) u_out_value_reg (
        .clk (in_clock), .rst (in_reset), .d (out_value_d), .q (out_value_q)
    );

    assign out_ready = (state_q == ST_IDLE) && !in_reset;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;

endmodule

// File: doc/share_unmask.md
SHARE_UNMASK -- requirements
Module: share_unmask

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2: number of Boolean shares recombined (2..5 supported).
REQ-002 SHALL have parameter BIT_WIDTH, default 2: bits per share and per output value.
REQ-003 SHALL have port in_clock, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port in_reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_shares, input, NUM_SHARES x BIT_WIDTH: shared value, packed array of T.
REQ-006 SHALL have port in_valid, input, 1: in_shares valid.
REQ-007 SHALL have port out_ready, output, 1: block accepts in_shares this cycle.
REQ-008 SHALL have port out_value, output, BIT_WIDTH: unmasked value (XOR of all shares).
REQ-009 SHALL have port out_valid, output, 1: out_value valid.
REQ-010 SHALL have port in_ready, input, 1: downstream accepts out_value.
REQ-011 SHALL have port in_random, input, num_share_0(NUM_SHARES) x BIT_WIDTH, present only with SHARE_UNMASK_REFRESH_EN: fresh randomness.

Function
REQ-012 SHALL implement FSM states IDLE, REFRESH (only with macro), ACCUM, DONE.
REQ-013 IDLE: out_ready=1; in_valid&&out_ready captures all shares into a share register bank, zeroes the accumulator and share index, next state ACCUM (REFRESH with macro).
REQ-014 ACCUM: one share per cycle, acc <= acc ^ share_reg[idx], idx 0..NUM_SHARES-1; never more than one share enters the XOR per cycle.
REQ-015 After the idx=NUM_SHARES-1 cycle, next state DONE; idx returns to 0 (no wrap beyond NUM_SHARES-1).
REQ-016 DONE: out_valid=1, out_value=acc held stable until in_valid... in_ready=1; then next state IDLE, share registers and acc cleared to 0.
REQ-017 Latency without macro: handshake in cycle t -> out_valid first high in cycle t+NUM_SHARES+1.
REQ-018 out_value SHALL be driven 0 whenever out_valid=0 (no partial sums visible).
REQ-019 out_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE ignored, in_shares not sampled.
REQ-020 DONE with in_ready=1 SHALL NOT accept new input in the same cycle (out_ready=0); next acceptance earliest one cycle later in IDLE.

Reset
REQ-021 in_reset=1 SHALL asynchronously force state IDLE, idx 0, acc 0, share registers 0, out_valid 0, out_value 0.
REQ-022 out_ready SHALL be 0 while in_reset=1, 1 in the first cycle after release.
REQ-023 Reset in any state mid-operation SHALL discard the in-flight value; no output is produced for it.

Configuration
REQ-024 Macro SHARE_UNMASK_REFRESH_EN SHALL add port in_random and state REFRESH.
REQ-025 With macro: in_random sampled in the capture cycle; in REFRESH (one cycle) share_reg[i] ^= zero[i], zero being the registered zero-sharing; latency NUM_SHARES+2; out_value unchanged.
REQ-026 Without macro: no in_random port, no REFRESH state, latency per REQ-017.

Structure
REQ-027 State enum typedef unmask_state_t SHALL live in aes128_package; num_share_0() reused from it.
REQ-028 Zero-sharing with macro SHALL instantiate existing sub-module share_zero (its output register supplies the one-cycle REFRESH timing); state/acc/share storage SHALL use the register module.
REQ-029 Unsupported NUM_SHARES SHALL raise an elaboration $error.

Verification (NUM_SHARES=3, BIT_WIDTH=8)
REQ-030 in_shares {0x56,0x34,0x12}, in_valid at t, in_ready=1 -> out_valid at t+4, out_value=0x70 one cycle, then out_ready=1 at t+5.
REQ-031 Same input, in_ready=0 for 5 cycles -> out_value=0x70 and out_valid held steady, out_ready=0 throughout; release -> IDLE next cycle.
REQ-032 in_valid held high continuously with changing shares -> only values present in IDLE cycles captured; each output equals XOR of its captured triple.
REQ-033 in_reset pulse in 2nd ACCUM cycle -> out_valid never asserts for that input, out_value=0, out_ready=1 after release.
REQ-034 Macro on, shares {0x56,0x34,0x12}, in_random {0x55,0xAA} -> out_value=0x70 at t+5; REFRESH-cycle share registers differ from captured ones.
REQ-035 Outside DONE, out_value=0 in every cycle of every scenario.
